// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving a 3-to-8 digit decoder.
// Each enabled digit gets a blanking gap, then a lit window.
module seg_scan_ctrl #(
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dig_mask,
  output logic        sel_a,
  output logic        sel_b,
  output logic        sel_c,
  output logic        g1,
  output logic        not_g2,
  output logic        not_g3,
  output logic [6:0]  seg_n,
  output logic        busy,
  output logic        frame_done
);

  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   sh_data;
  logic [7:0]    sh_mask;
  logic [2:0]    sel;
  logic [2:0]    first_idx;
  logic [2:0]    next_idx;
  logic          has_next;
  logic          start;
  logic [3:0]    nib;
  logic [6:0]    dec;

  assign start = en && (dig_mask != 8'h00);

  assign sel_a = sel[0];
  assign sel_b = sel[1];
  assign sel_c = sel[2];

  // Lowest set bit of the incoming mask (first digit of a new frame).
  always_comb begin
    first_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dig_mask[i]) first_idx = 3'(i);
    end
  end

  // Lowest set shadow-mask bit above the current digit.
  always_comb begin
    next_idx = 3'd0;
    has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (sh_mask[i] && (3'(i) > sel)) begin
        next_idx = 3'(i);
        has_next = 1'b1;
      end
    end
  end

  // Hex-to-segment decode of the shadow nibble under the current select.
  always_comb begin
    nib = sh_data[{sel, 2'b00} +: 4];
    unique case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end

  assign seg_n = (state == IDLE) ? 7'h7F : dec;

  // Scan FSM: latches a frame, walks set digits, pulses at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh_data    <= '0;
      sh_mask    <= '0;
      sel        <= 3'd0;
      g1         <= 1'b0;
      not_g2     <= 1'b1;
      not_g3     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= BLANK;
            cnt     <= '0;
            sh_data <= data;
            sh_mask <= dig_mask;
            sel     <= first_idx;
            busy    <= 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state  <= SHOW;
            cnt    <= '0;
            g1     <= 1'b1;
            not_g2 <= 1'b0;
            not_g3 <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt    <= '0;
            g1     <= 1'b0;
            not_g2 <= 1'b1;
            not_g3 <= 1'b1;
            if (has_next) begin
              state <= BLANK;
              sel   <= next_idx;
            end else begin
              frame_done <= 1'b1;
              if (start) begin
                state   <= BLANK;
                sh_data <= data;
                sh_mask <= dig_mask;
                sel     <= first_idx;
              end else begin
                state <= IDLE;
                sel   <= 3'd0;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-frame expected waveform queue model,
// directed scenarios followed by randomized traffic.
module tb_seg_scan_ctrl;

  localparam int SC = 4;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dig_mask = '0;
  logic        sel_a, sel_b, sel_c;
  logic        g1, not_g2, not_g3;
  logic [6:0]  seg_n;
  logic        busy, frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SHOW_CYC(SC), .BLANK_CYC(BC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .data(data),
    .dig_mask(dig_mask),
    .sel_a(sel_a),
    .sel_b(sel_b),
    .sel_c(sel_c),
    .g1(g1),
    .not_g2(not_g2),
    .not_g3(not_g3),
    .seg_n(seg_n),
    .busy(busy),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic       on;
    logic [2:0] sel;
    logic [6:0] seg;
  } ent_t;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  ent_t q[$];
  bit   fd_exp = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Whole frame as a list of per-cycle expected outputs.
  task automatic load(input logic [31:0] d, input logic [7:0] m);
    ent_t e;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.sel = 3'(i);
        e.seg = hex_tab[d[4*i +: 4]];
        e.on  = 1'b0;
        repeat (BC) q.push_back(e);
        e.on  = 1'b1;
        repeat (SC) q.push_back(e);
      end
    end
  endtask

  task automatic model_edge();
    fd_exp = 1'b0;
    if (!rst_n) begin
      q.delete();
      return;
    end
    if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() != 0) return;
      fd_exp = 1'b1;
    end
    if (en && dig_mask != 8'h00) load(data, dig_mask);
  endtask

  task automatic check_out();
    if (q.size() > 0) begin
      chk("g1", g1, q[0].on);
      chk("not_g2", not_g2, !q[0].on);
      chk("not_g3", not_g3, !q[0].on);
      chk("sel", {sel_c, sel_b, sel_a}, q[0].sel);
      chk("seg_n", seg_n, q[0].seg);
      chk("busy", busy, 1);
    end else begin
      chk("g1", g1, 0);
      chk("not_g2", not_g2, 1);
      chk("not_g3", not_g3, 1);
      chk("sel", {sel_c, sel_b, sel_a}, 0);
      chk("seg_n", seg_n, 7'h7F);
      chk("busy", busy, 0);
    end
    chk("frame_done", frame_done, fd_exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    fd_exp = 1'b0;
    check_out();
    step();
    rst_n = 1'b1;
  endtask

  int flen;
  int guard;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Full 8-digit frame with an incrementing pattern.
    data = 32'h76543210;
    dig_mask = 8'hFF;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (55) step();

    // Sparse mask: only digits 0, 2, 7; measure frame length.
    data = $urandom;
    dig_mask = 8'h85;
    en = 1'b1;
    step();
    en = 1'b0;
    flen = 0;
    while (flen < 200) begin
      step();
      flen++;
      if (frame_done) break;
    end
    chk("frame_len", flen, 3 * (BC + SC));
    repeat (5) step();

    // Data change mid-frame only lands on the next frame.
    data = 32'h76543210;
    dig_mask = 8'hFF;
    en = 1'b1;
    step();
    repeat (10) step();
    data = 32'hFFFFFFFF;
    repeat (100) step();
    en = 1'b0;
    repeat (60) step();

    // Dropping en mid-frame must not truncate the scan.
    data = $urandom;
    dig_mask = 8'hFF;
    en = 1'b1;
    step();
    repeat (3 * (BC + SC) + 2) step();
    en = 1'b0;
    repeat (40) step();

    // Reset while a digit is lit.
    data = $urandom;
    dig_mask = 8'h3C;
    en = 1'b1;
    step();
    guard = 0;
    while (!(q.size() > 0 && q[0].on) && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_show", guard < 100, 1);
    step();
    async_reset();
    en = 1'b0;
    repeat (3) step();

    // Empty mask never starts a scan.
    en = 1'b1;
    dig_mask = 8'h00;
    repeat (100) step();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom % 4) != 0;
      dig_mask = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      if (($urandom % 4) == 0) data = $urandom;
      if (($urandom % 500) == 0) async_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
